mem_port_arbiter: RTL

//  Shares the single RAM port between instruction fetch (IF) and data load/store (D) requesters.

---
 rtl/mem_arb_pkg.sv | 39 +++
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/arb_sat_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the single-port RAM arbiter.
// FSM states, access-size / direction codes, grant codes and small helpers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef logic [1:0] size_t;
    typedef logic [1:0] grant_t;

    localparam size_t SZ_BYTE = 2'b00;
    localparam size_t SZ_HALF = 2'b01;
    localparam size_t SZ_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam grant_t GRANT_NONE = 2'b00;
    localparam grant_t GRANT_IF   = 2'b01;
    localparam grant_t GRANT_D    = 2'b10;

    // The reserved size code 11 goes to the RAM as a plain word access.
    function automatic size_t norm_size(input size_t sz);
        case (sz)
            SZ_BYTE: return SZ_BYTE;
            SZ_HALF: return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester + RAM bus bundle around the arbiter; slave = arbiter view, master = CPU/RAM view.
// All arbiter outputs are registered; requests are levels held until the matching ack.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_rw;
    size_t       d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;

    logic        mem_mov;
    logic        mem_rw;
    size_t       mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_moc;
    logic [31:0] mem_rdata;

    grant_t      grant;
    logic        timeout_err;

    modport slave (
        input  if_req, if_addr, d_req, d_rw, d_size, d_addr, d_wdata, mem_moc, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_mov, mem_rw, mem_size, mem_addr,
               mem_wdata, grant, timeout_err
    );

    modport master (
        output if_req, if_addr, d_req, d_rw, d_size, d_addr, d_wdata, mem_moc, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_mov, mem_rw, mem_size, mem_addr,
               mem_wdata, grant, timeout_err
    );

endinterface

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment); 1-cycle update.
// No backpressure: increments past MAX are dropped.
module arb_sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_V)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between fetch and data; 3 cycles request->ack, 4 cycles per back-to-back access.
// Requests are held levels, sampled only in IDLE; a missing MOC is aborted after TIMEOUT_CYC cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave arb_bus
);
    localparam int SW = cnt_width(STARVE_MAX);
    localparam int TW = cnt_width(TIMEOUT_CYC);
    localparam logic [SW-1:0] STARVE_FULL = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYC - 1);
    localparam bit            TO_EN       = (TIMEOUT_CYC != 0);

    arb_state_t  r_state, w_state_nxt;
    logic        r_mov, w_mov_nxt;
    logic        r_rw, w_rw_nxt;
    size_t       r_size, w_size_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic        r_if_ack, w_if_ack_nxt;
    logic [31:0] r_if_rdata, w_if_rdata_nxt;
    logic        r_d_ack, w_d_ack_nxt;
    logic [31:0] r_d_rdata, w_d_rdata_nxt;
    grant_t      r_grant, w_grant_nxt;
    logic        r_to_err, w_to_err_nxt;

    logic          w_st_clr, w_st_inc, w_to_clr, w_to_inc;
    logic [SW-1:0] w_starve_cnt;
    logic [TW-1:0] w_to_cnt;
    logic          w_starve_full, w_to_hit;

    arb_sat_counter #(.WIDTH(SW), .MAX(STARVE_MAX)) u_starve_cnt (
        .clk   (clk),
        .rst_n (reset),
        .i_clr (w_st_clr),
        .i_inc (w_st_inc),
        .o_cnt (w_starve_cnt)
    );

    arb_sat_counter #(.WIDTH(TW), .MAX(TIMEOUT_CYC)) u_timeout_cnt (
        .clk   (clk),
        .rst_n (reset),
        .i_clr (w_to_clr),
        .i_inc (w_to_inc),
        .o_cnt (w_to_cnt)
    );

    assign w_starve_full = (w_starve_cnt == STARVE_FULL);
    // Counter holds the number of MOC-less cycles already spent; this is the last allowed one.
    assign w_to_hit      = TO_EN && (w_to_cnt == TO_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_mov_nxt      = r_mov;
        w_rw_nxt       = r_rw;
        w_size_nxt     = r_size;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_if_ack_nxt   = 1'b0;
        w_if_rdata_nxt = r_if_rdata;
        w_d_ack_nxt    = 1'b0;
        w_d_rdata_nxt  = r_d_rdata;
        w_grant_nxt    = r_grant;
        w_to_err_nxt   = r_to_err;
        w_st_clr       = 1'b0;
        w_st_inc       = 1'b0;
        w_to_clr       = 1'b0;
        w_to_inc       = 1'b0;

        case (r_state)
            IDLE: begin
                if (arb_bus.d_req && !(arb_bus.if_req && w_starve_full)) begin
                    w_state_nxt = GNT_D;
                    w_mov_nxt   = 1'b1;
                    w_rw_nxt    = arb_bus.d_rw;
                    w_size_nxt  = norm_size(arb_bus.d_size);
                    w_addr_nxt  = arb_bus.d_addr;
                    w_wdata_nxt = arb_bus.d_wdata;
                    w_grant_nxt = GRANT_D;
                    w_to_clr    = 1'b1;
                    w_st_inc    = arb_bus.if_req;
                end else if (arb_bus.if_req) begin
                    w_state_nxt = GNT_I;
                    w_mov_nxt   = 1'b1;
                    w_rw_nxt    = RW_READ;
                    w_size_nxt  = SZ_WORD;
                    w_addr_nxt  = arb_bus.if_addr;
                    w_wdata_nxt = '0;
                    w_grant_nxt = GRANT_IF;
                    w_to_clr    = 1'b1;
                    w_st_clr    = 1'b1;
                end
            end

            GNT_I, GNT_D: begin
                // MOC is tested first so a completion on the expiry cycle still delivers data.
                if (arb_bus.mem_moc || w_to_hit) begin
                    w_state_nxt = DONE;
                    w_mov_nxt   = 1'b0;
                    w_grant_nxt = GRANT_NONE;
                    if (r_state == GNT_I) begin
                        w_if_ack_nxt   = 1'b1;
                        w_if_rdata_nxt = arb_bus.mem_moc ? arb_bus.mem_rdata : '0;
                    end else begin
                        w_d_ack_nxt = 1'b1;
                        if (!arb_bus.mem_moc) begin
                            w_d_rdata_nxt = '0;
                        end else if (r_rw == RW_READ) begin
                            w_d_rdata_nxt = arb_bus.mem_rdata;
                        end
                    end
                    if (!arb_bus.mem_moc) begin
                        w_to_err_nxt = 1'b1;
                    end
                end else begin
                    w_to_inc = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_mov      <= 1'b0;
            r_rw       <= 1'b0;
            r_size     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_ack   <= 1'b0;
            r_if_rdata <= '0;
            r_d_ack    <= 1'b0;
            r_d_rdata  <= '0;
            r_grant    <= GRANT_NONE;
            r_to_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mov      <= w_mov_nxt;
            r_rw       <= w_rw_nxt;
            r_size     <= w_size_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_if_ack   <= w_if_ack_nxt;
            r_if_rdata <= w_if_rdata_nxt;
            r_d_ack    <= w_d_ack_nxt;
            r_d_rdata  <= w_d_rdata_nxt;
            r_grant    <= w_grant_nxt;
            r_to_err   <= w_to_err_nxt;
        end
    end

    assign arb_bus.mem_mov     = r_mov;
    assign arb_bus.mem_rw      = r_rw;
    assign arb_bus.mem_size    = r_size;
    assign arb_bus.mem_addr    = r_addr;
    assign arb_bus.mem_wdata   = r_wdata;
    assign arb_bus.if_ack      = r_if_ack;
    assign arb_bus.if_rdata    = r_if_rdata;
    assign arb_bus.d_ack       = r_d_ack;
    assign arb_bus.d_rdata     = r_d_rdata;
    assign arb_bus.grant       = r_grant;
    assign arb_bus.timeout_err = r_to_err;

endmodule
